// File: rtl/aes_block_assembler.sv
// aes_block_assembler: collects a valid/ready byte stream into NBYTES-byte blocks,
// double-buffered against a valid/ready block consumer, with an optional idle timeout.
module aes_block_assembler #(
  parameter int unsigned NBYTES  = 16,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_data,
  input  logic                         msb_first,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NBYTES*8-1:0]          out_state,
  output logic [$clog2(NBYTES+1)-1:0]  byte_cnt,
  output logic                         err_timeout
);

  localparam int unsigned W  = NBYTES * 8;
  localparam int unsigned CW = $clog2(NBYTES + 1);
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  logic [W-1:0]  collect;
  logic [W-1:0]  merged;
  logic          mode;
  logic          accept;
  logic          last_byte;
  logic          drain;
  logic          eff_mode;
  logic          hit;
  logic [CW-1:0] pos;

  // Final byte only goes in when the output slot is free or draining this cycle
  assign in_ready  = rst_n && !clear && ((byte_cnt != LAST) || !out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign last_byte = (byte_cnt == LAST);
  assign drain     = out_valid && out_ready;

  // Byte 0 uses the live mode input; later bytes use the mode latched on byte 0
  assign eff_mode = (byte_cnt == '0) ? msb_first : mode;
  assign pos      = eff_mode ? CW'(LAST - byte_cnt) : byte_cnt;

  // Collect buffer with the incoming byte dropped into its lane
  always_comb begin
    merged = collect;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (pos == CW'(i)) merged[i*8 +: 8] = in_data;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_timer
      logic [TW-1:0] timer;
      logic          idle;

      assign idle = (byte_cnt != '0) && !in_valid;
      assign hit  = idle && (timer == TW'(TIMEOUT - 1));

      // Idle timer: counts partial-block cycles with no offered byte; stalls hold it
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          timer <= '0;
        end else if (clear || accept || hit || (byte_cnt == '0)) begin
          timer <= '0;
        end else if (idle) begin
          timer <= timer + TW'(1);
        end
      end
    end else begin : g_no_timer
      assign hit = 1'b0;
    end
  endgenerate

  // Block assembly, output slot and timeout pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collect     <= '0;
      out_state   <= '0;
      out_valid   <= 1'b0;
      byte_cnt    <= '0;
      err_timeout <= 1'b0;
      mode        <= 1'b1;
    end else begin
      err_timeout <= 1'b0;
      if (clear) begin
        byte_cnt  <= '0;
        out_valid <= 1'b0;
      end else begin
        if (accept) begin
          if (byte_cnt == '0) mode <= msb_first;
          if (last_byte) begin
            out_state <= merged;
            out_valid <= 1'b1;
            byte_cnt  <= '0;
          end else begin
            collect  <= merged;
            byte_cnt <= byte_cnt + CW'(1);
          end
        end else if (hit) begin
          byte_cnt    <= '0;
          err_timeout <= 1'b1;
        end
        if (drain && !(accept && last_byte)) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_block_assembler.sv
// Directed testbench for aes_block_assembler: one instance with TIMEOUT=8, one with TIMEOUT=0.
module tb_aes_block_assembler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         msb_first = 1'b1;
  logic         out_ready = 1'b1;

  logic         in_ready_a, out_valid_a, err_a;
  logic [127:0] state_a;
  logic [4:0]   cnt_a;
  logic         in_ready_b, out_valid_b, err_b;
  logic [127:0] state_b;
  logic [4:0]   cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aes_block_assembler #(.NBYTES(16), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .msb_first(msb_first), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_state(state_a), .byte_cnt(cnt_a), .err_timeout(err_a)
  );

  aes_block_assembler #(.NBYTES(16), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .msb_first(msb_first), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_state(state_b), .byte_cnt(cnt_b), .err_timeout(err_b)
  );

  typedef struct {
    string        name;
    logic         msb;
    logic         msb_mid;
    logic [127:0] stream;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer one byte and hold it until accepted; returns at posedge+1 of the accept edge
  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   guard;
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    acc      = 1'b0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = in_ready_a;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %h not accepted, in_ready=%b required 1", b, in_ready_a);
    end
  endtask

  // Send the first n bytes of a stream (byte i = stream[127-8i -: 8]), mode switched at byte 7
  task automatic send_bytes(input logic [127:0] stream, input int n, input logic msb, input logic mid);
    msb_first = msb;
    for (int i = 0; i < n; i++) begin
      if (i == 7) msb_first = mid;
      send_byte(stream[127-8*i -: 8]);
    end
  endtask

  localparam logic [127:0] S1   = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] SSEQ = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SB   = 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0;

  initial begin
    int pulses;
    int pulse_at;
    int pulses_b;
    logic [4:0] cnt_at_pulse;

    vecs[0] = '{"msb_first", 1'b1, 1'b1, S1,   S1};
    vecs[1] = '{"lsb_mid_switch", 1'b0, 1'b1, S1, 128'h1032547698badcfeefcdab8967452301};
    vecs[2] = '{"lsb_seq", 1'b0, 1'b0, SSEQ, 128'h0f0e0d0c0b0a09080706050403020100};
    vecs[3] = '{"msb_mid_switch", 1'b1, 1'b0, SSEQ, SSEQ};

    // Reset state
    #1;
    chk("rst_in_ready", 128'(in_ready_a), 128'(0));
    chk("rst_out_valid", 128'(out_valid_a), 128'(0));
    chk("rst_state", state_a, 128'(0));
    chk("rst_cnt", 128'(cnt_a), 128'(0));
    chk("rst_err", 128'(err_a), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven block assembly
    out_ready = 1'b1;
    foreach (vecs[k]) begin
      send_bytes(vecs[k].stream, 16, vecs[k].msb, vecs[k].msb_mid);
      chk({vecs[k].name, "_valid"}, 128'(out_valid_a), 128'(1));
      chk({vecs[k].name, "_state"}, state_a, vecs[k].exp);
      chk({vecs[k].name, "_state_b"}, state_b, vecs[k].exp);
      chk({vecs[k].name, "_cnt"}, 128'(cnt_a), 128'(0));
    end
    @(posedge clk);
    #1;
    chk("drain_valid", 128'(out_valid_a), 128'(0));
    chk("drain_keeps_state", state_a, SSEQ);

    // Backpressure and double buffering
    send_bytes(SSEQ, 16, 1'b1, 1'b1);
    out_ready = 1'b0;
    send_bytes(SB, 15, 1'b1, 1'b1);
    chk("bp_cnt15", 128'(cnt_a), 128'(15));
    in_valid = 1'b1;
    in_data  = 8'hf0;
    #1;
    chk("bp_in_ready_low", 128'(in_ready_a), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("bp_hold_valid", 128'(out_valid_a), 128'(1));
    chk("bp_hold_state", state_a, SSEQ);
    chk("bp_hold_cnt", 128'(cnt_a), 128'(15));
    chk("bp_hold_ready", 128'(in_ready_a), 128'(0));
    out_ready = 1'b1;
    #1;
    chk("bp_ready_with_drain", 128'(in_ready_a), 128'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_swap_valid", 128'(out_valid_a), 128'(1));
    chk("bp_swap_state", state_a, SB);
    chk("bp_swap_cnt", 128'(cnt_a), 128'(0));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_final_drain", 128'(out_valid_a), 128'(0));

    // Timeout: dut_a discards after 8 idle cycles, dut_b never does
    send_bytes(S1, 5, 1'b1, 1'b1);
    pulses = 0;
    pulse_at = -1;
    pulses_b = 0;
    cnt_at_pulse = 5'h1f;
    for (int c = 1; c <= 1000; c++) begin
      @(posedge clk);
      #1;
      if (err_a) begin
        pulses++;
        pulse_at = c;
        cnt_at_pulse = cnt_a;
      end
      if (err_b) pulses_b++;
    end
    chk("to_pulse_count", 128'(pulses), 128'(1));
    chk("to_pulse_cycle", 128'(pulse_at), 128'(8));
    chk("to_cnt_cleared", 128'(cnt_at_pulse), 128'(0));
    chk("to0_cnt_kept", 128'(cnt_b), 128'(5));
    chk("to0_no_pulse", 128'(pulses_b), 128'(0));
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("to0_clear_cnt", 128'(cnt_b), 128'(0));
    send_bytes(SSEQ, 16, 1'b1, 1'b1);
    chk("to_clean_block", state_a, SSEQ);
    chk("to_clean_block_b", state_b, SSEQ);
    @(posedge clk);
    #1;

    // Clear with a partial block and a pending output
    send_bytes(S1, 16, 1'b1, 1'b1);
    out_ready = 1'b0;
    send_bytes(SSEQ, 9, 1'b0, 1'b0);
    chk("clr_pre_cnt", 128'(cnt_a), 128'(9));
    chk("clr_pre_valid", 128'(out_valid_a), 128'(1));
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'haa;
    #1;
    chk("clr_in_ready", 128'(in_ready_a), 128'(0));
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_cnt", 128'(cnt_a), 128'(0));
    chk("clr_valid", 128'(out_valid_a), 128'(0));
    chk("clr_state_kept", state_a, S1);
    out_ready = 1'b1;
    send_bytes(SB, 16, 1'b1, 1'b1);
    chk("clr_next_block", state_a, SB);

    // Asynchronous reset during block fill
    send_bytes(S1, 6, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", 128'(cnt_a), 128'(0));
    chk("arst_valid", 128'(out_valid_a), 128'(0));
    chk("arst_state", state_a, 128'(0));
    chk("arst_in_ready", 128'(in_ready_a), 128'(0));
    chk("arst_err", 128'(err_a), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_bytes(S1, 16, 1'b0, 1'b0);
    chk("arst_after_valid", 128'(out_valid_a), 128'(1));
    chk("arst_after_state", state_a, 128'h1032547698badcfeefcdab8967452301);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
